dco_phase_accum: RTL and testbench

Digitally controlled oscillator that closes the CDR loop on the consumer side of the loop filter's `v_ctrl` word. It converts the signed control word into a clamped frequency control word (FCW) around a nominal rate. It advances a phase accumulator and emits sample and edge strobes that drive the phase detector and the data sampler. A watchdog freezes the FCW and flags holdover when control updates stop arriving.

---
 rtl/cdr_pkg.sv | 20 ++
 rtl/lfsr16.sv | 25 ++
 rtl/dco_phase_accum.sv | 118 +++++++++++
 tb/tb_dco_phase_accum.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared CDR definitions: control word type, FCW clip helper and LFSR constants.
package cdr_pkg;

  localparam int PHASE_W_DEF = 32;

  typedef logic signed [31:0] ctrl_t;

  // x^16 + x^14 + x^13 + x^11 as a Fibonacci tap mask on state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] clip32(input logic signed [33:0] x,
                                         input logic [31:0]        lo,
                                         input logic [31:0]        hi);
    if (x < $signed({2'b00, lo}))      return lo;
    else if (x > $signed({2'b00, hi})) return hi;
    else                               return x[31:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to dither the DCO addend; steps only when enabled.
module lfsr16
  import cdr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LFSR_SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/dco_phase_accum.sv
// CDR digitally controlled oscillator: clamped FCW, phase accumulator, wrap/half
// strobes and a holdover watchdog. Define DCO_DITHER_EN to dither the addend LSBs.
module dco_phase_accum
  import cdr_pkg::*;
#(
  parameter int          PHASE_W     = PHASE_W_DEF,
  parameter logic [31:0] FCW_NOM     = 32'h2000_0000,
  parameter int          GAIN_SH     = 8,
  parameter logic [31:0] FCW_MIN     = 32'h0100_0000,
  parameter logic [31:0] FCW_MAX     = 32'h6000_0000,
  parameter int          HOLD_CYC    = 1024,
  parameter int          DITHER_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  ctrl_t              v_ctrl,
  input  logic               v_valid,
  input  logic               en,
  output logic [PHASE_W-1:0] phase,
  output logic [31:0]        fcw,
  output logic               sample_stb,
  output logic               edge_stb,
  output logic               holdover
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  // A max FCW below half scale is what guarantees one event per step at most.
  if (FCW_MIN == 32'd0 || {32'd0, FCW_MAX} >= (64'd1 << (PHASE_W - 1)) ||
      DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_bad_cfg
    $error("dco_phase_accum: illegal FCW clamp or dither configuration");
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        fcw_q, fcw_d;
  logic               sample_q, sample_d;
  logic               edge_q, edge_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  ctrl_t              off;
  logic signed [33:0] fcw_sum;
  logic [PHASE_W-1:0] addend;
  logic [PHASE_W:0]   acc;

`ifdef DCO_DITHER_EN
  logic [15:0] lfsr_state;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (lfsr_state)
  );

  assign addend = PHASE_W'(fcw_q) ^ PHASE_W'(lfsr_state[DITHER_BITS-1:0]);
`else
  assign addend = PHASE_W'(fcw_q);
`endif

  always_comb begin
    off      = v_ctrl >>> GAIN_SH;
    fcw_sum  = $signed({2'b00, FCW_NOM}) + $signed({{2{off[31]}}, off});
    acc      = {1'b0, phase_q} + {1'b0, addend};

    fcw_d    = fcw_q;
    phase_d  = phase_q;
    sample_d = 1'b0;
    edge_d   = 1'b0;
    cnt_d    = cnt_q;
    hold_d   = hold_q;

    if (en) begin
      phase_d  = acc[PHASE_W-1:0];
      sample_d = acc[PHASE_W];
      edge_d   = ~phase_q[PHASE_W-1] & acc[PHASE_W-1];
    end

    // A fresh update beats an expiring watchdog on the same edge.
    if (v_valid) begin
      fcw_d  = clip32(fcw_sum, FCW_MIN, FCW_MAX);
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (en) begin
      if (cnt_q >= CNT_W'(HOLD_CYC - 1)) begin
        cnt_d  = CNT_W'(HOLD_CYC);
        hold_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      fcw_q    <= FCW_NOM;
      sample_q <= 1'b0;
      edge_q   <= 1'b0;
      hold_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      fcw_q    <= fcw_d;
      sample_q <= sample_d;
      edge_q   <= edge_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
    end
  end

  assign phase      = phase_q;
  assign fcw        = fcw_q;
  assign sample_stb = sample_q;
  assign edge_stb   = edge_q;
  assign holdover   = hold_q;

endmodule

// File: tb/tb_dco_phase_accum.sv
// Directed + random bench for dco_phase_accum against an arithmetic reference model.
module tb_dco_phase_accum;

  localparam int     GAIN_SH = 0;
  localparam int     HOLD    = 16;
  localparam longint NOM     = 64'h2000_0000;
  localparam longint FMIN    = 64'h0100_0000;
  localparam longint FMAX    = 64'h6000_0000;
  localparam longint TWO32   = 64'h1_0000_0000;
  localparam longint HALF    = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, v_valid, en;
  logic [31:0] v_ctrl;
  logic [31:0] phase, fcw;
  logic        sample_stb, edge_stb, holdover;

  dco_phase_accum #(.GAIN_SH(GAIN_SH), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .v_ctrl     (v_ctrl),
    .v_valid    (v_valid),
    .en         (en),
    .phase      (phase),
    .fcw        (fcw),
    .sample_stb (sample_stb),
    .edge_stb   (edge_stb),
    .holdover   (holdover)
  );

  always #5 clk = ~clk;

  longint m_phase, m_fcw, m_since;
  bit     m_s, m_e, m_hold;
  int     n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then compare.
  task automatic step();
    longint nxt, off, sum;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_fcw = NOM; m_s = 0; m_e = 0; m_hold = 0; m_since = 0;
    end else begin
      if (en) begin
        nxt     = m_phase + m_fcw;
        m_s     = (nxt >= TWO32);
        m_e     = (m_phase < HALF) && ((nxt % TWO32) >= HALF);
        m_phase = nxt % TWO32;
      end else begin
        m_s = 0; m_e = 0;
      end
      if (v_valid) begin
        off      = longint'($signed(v_ctrl)) >>> GAIN_SH;
        sum      = NOM + off;
        m_fcw    = (sum < FMIN) ? FMIN : (sum > FMAX) ? FMAX : sum;
        m_since  = 0;
        m_hold   = 0;
      end else if (en) begin
        m_since++;
        m_hold = (m_since >= HOLD);
      end
    end
    #1;
    chk("phase",      64'(phase),      64'(m_phase));
    chk("fcw",        64'(fcw),        64'(m_fcw));
    chk("sample_stb", 64'(sample_stb), 64'(m_s));
    chk("edge_stb",   64'(edge_stb),   64'(m_e));
    chk("holdover",   64'(holdover),   64'(m_hold));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; v_valid = 1'b0; v_ctrl = '0;
    m_phase = 0; m_fcw = NOM; m_since = 0; m_s = 0; m_e = 0; m_hold = 0;
    step(); step();
    chk("reset_phase", 64'(phase), 64'd0);
    chk("reset_fcw",   64'(fcw),   64'h2000_0000);

    // Free run at nominal rate; watchdog expires on the 16th enabled edge
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 4 || i == 12) chk("edge_cadence",   64'(edge_stb),   64'd1);
      if (i == 8 || i == 16) chk("sample_cadence", 64'(sample_stb), 64'd1);
    end
    chk("hold_expired", 64'(holdover), 64'd1);
    chk("hold_fcw",     64'(fcw),      64'h2000_0000);

    // Double the rate; update also clears holdover
    v_ctrl = 32'h2000_0000; v_valid = 1'b1; step(); v_valid = 1'b0;
    chk("fcw_double",  64'(fcw),      64'h4000_0000);
    chk("hold_clears", 64'(holdover), 64'd0);
    repeat (12) step();

    // Clamps
    v_valid = 1'b1;
    v_ctrl = 32'h7FFF_FFFF; step();
    chk("clamp_hi", 64'(fcw), 64'h6000_0000);
    v_ctrl = 32'h8000_0001; step();
    chk("clamp_lo", 64'(fcw), 64'h0100_0000);
    v_ctrl = 32'h0000_0000; step();
    v_valid = 1'b0;

    // Update on the expiring cycle wins; later expiry then clears on update
    repeat (15) step();
    v_valid = 1'b1; step(); v_valid = 1'b0;
    chk("valid_wins", 64'(holdover), 64'd0);
    repeat (16) step();
    chk("hold_again", 64'(holdover), 64'd1);
    v_valid = 1'b1; step(); v_valid = 1'b0;
    chk("hold_clear2", 64'(holdover), 64'd0);

    // Enable gap mid-period
    repeat (3) step();
    en = 1'b0; repeat (5) step();
    en = 1'b1; repeat (20) step();

    // Randomized traffic
    repeat (400) begin
      en      = ($urandom % 8) != 0;
      v_valid = ($urandom % 16) == 0;
      v_ctrl  = ($urandom % 2) ? $urandom : ($urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000);
      rst     = ($urandom % 200) == 0;
      step();
    end
    rst = 1'b0; en = 1'b1; v_valid = 1'b0;
    repeat (10) step();

    // Reset overrides a concurrent update
    v_valid = 1'b1; v_ctrl = 32'h1000_0000; rst = 1'b1;
    step();
    rst = 1'b0; v_valid = 1'b0;
    chk("rst_ovr_phase",  64'(phase),      64'd0);
    chk("rst_ovr_fcw",    64'(fcw),        64'h2000_0000);
    chk("rst_ovr_sample", 64'(sample_stb), 64'd0);
    chk("rst_ovr_edge",   64'(edge_stb),   64'd0);
    chk("rst_ovr_hold",   64'(holdover),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
